// File: rtl/udp_pkg.sv
// Shared constants, packer state encoding and length helpers for the UDP transmit path.
package udp_pkg;

  localparam int UDP_HDR_BYTES   = 8;
  localparam int IPV4_HDR_BYTES  = 20;
  localparam int UDP_MAX_PAYLOAD = 1472;

  localparam logic [15:0] SEQ_MAGIC = 16'hA55A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    GAP
  } state_e;

  function automatic logic [15:0] udp_length(input int payload_bytes);
    return 16'(UDP_HDR_BYTES + payload_bytes);
  endfunction

  function automatic logic [15:0] ip_total_length(input int payload_bytes);
    return 16'(IPV4_HDR_BYTES + UDP_HDR_BYTES + payload_bytes);
  endfunction

endpackage

// File: rtl/udp_tx_packer_if.sv
// Sample-stream and UDP-stage handshake bundle; master is the packer, slave is its environment.
interface udp_tx_packer_if;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        tx_start;
  logic        tx_data_req;
  logic [31:0] tx_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;

  modport master (
    input  s_valid, s_data, tx_data_req,
    output s_ready, tx_start, tx_data, tx_data_length, tx_total_length
  );

  modport slave (
    output s_valid, s_data, tx_data_req,
    input  s_ready, tx_start, tx_data, tx_data_length, tx_total_length
  );

endinterface

// File: rtl/udp_tx_fifo.sv
// Synchronous-read RAM FIFO with occupancy count; rdata updates only on a pop and holds otherwise.
module udp_tx_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  push_en;
  logic                  pop_en;

  assign full_o  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && (level_q != '0);

  // NOTE: the storage array has no reset so it maps onto block RAM; only pointers and level are reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem_q[rd_ptr_q];
      end
      case ({push_en, pop_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign level_o = level_q;

endmodule

// File: rtl/udp_tx_packer.sv
// Buffers sample words and frames them into fixed-size UDP payloads with an inter-packet gap.
// Define UDP_TX_FRAME_HDR_EN to prepend a {SEQ_MAGIC, seq} word to every packet.
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int DEPTH_LOG2    = 9,
  parameter int PAYLOAD_WORDS = 256,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                  e_rxc,
  input  logic                  rst,
  udp_tx_packer_if.master       bus,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           pkt_count,
  output logic                  req_err
);

`ifdef UDP_TX_FRAME_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int TOTAL_WORDS   = PAYLOAD_WORDS + HDR_WORDS;
  localparam int PAYLOAD_BYTES = 4 * TOTAL_WORDS;
  localparam int CNT_W         = $clog2(TOTAL_WORDS + 1);
  localparam int GAP_W         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    word_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                req_err_q;
  logic [15:0]         pkt_count_q;

  logic                req_in_send;
  logic                last_word;
  logic                pop;
  logic [31:0]         fifo_rdata;
  logic                fifo_full;

  assign req_in_send = bus.tx_data_req && (state_q == SEND);
  assign last_word   = (word_cnt_q == CNT_W'(TOTAL_WORDS - 1));

  assign bus.tx_data_length  = udp_length(PAYLOAD_BYTES);
  assign bus.tx_total_length = ip_total_length(PAYLOAD_BYTES);

`ifdef UDP_TX_FRAME_HDR_EN
  logic [15:0] seq_q;
  logic        hdr_sel_q;
  logic [31:0] hdr_word_q;

  // The header slot is synthesised locally, so word 0 never touches the FIFO.
  assign pop = req_in_send && (word_cnt_q != '0);

  always_ff @(posedge e_rxc or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      hdr_sel_q  <= 1'b0;
      hdr_word_q <= '0;
    end else if (req_in_send) begin
      hdr_sel_q <= (word_cnt_q == '0);
      if (word_cnt_q == '0) hdr_word_q <= {SEQ_MAGIC, seq_q};
      if (last_word)        seq_q      <= seq_q + 16'd1;
    end
  end

  assign bus.tx_data = hdr_sel_q ? hdr_word_q : fifo_rdata;
`else
  assign pop         = req_in_send;
  assign bus.tx_data = fifo_rdata;
`endif

  udp_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clk     (e_rxc),
    .rst     (rst),
    .push_i  (bus.s_valid),
    .wdata_i (bus.s_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full)
  );

  assign bus.s_ready = !fifo_full;

  // NOTE: every register in this block is updated with <= so all branches see the pre-edge state.
  always_ff @(posedge e_rxc or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_err_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (bus.tx_data_req && (state_q != SEND)) req_err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (fifo_level >= (DEPTH_LOG2+1)'(PAYLOAD_WORDS)) begin
            state_q    <= START;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          state_q     <= SEND;
          word_cnt_q  <= '0;
          pkt_count_q <= pkt_count_q + 16'd1;
        end
        SEND: begin
          if (bus.tx_data_req) begin
            if (last_word) begin
              word_cnt_q <= '0;
              // GAP plus the single IDLE evaluation cycle together span GAP_CYCLES idle cycles.
              if (GAP_CYCLES > 1) begin
                state_q   <= GAP;
                gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign busy         = busy_q;
  assign pkt_count    = pkt_count_q;
  assign req_err      = req_err_q;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Self-checking bench for udp_tx_packer against a queue-based model of buffering, framing and pacing.
module tb_udp_tx_packer;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int PW         = 256;
  localparam int GAP        = 16;
`ifdef UDP_TX_FRAME_HDR_EN
  localparam int HDR_W = 1;
`else
  localparam int HDR_W = 0;
`endif
  localparam int TOTAL   = PW + HDR_W;
  localparam int P_BYTES = 4 * TOTAL;

  logic                e_rxc = 1'b0;
  logic                rst   = 1'b1;
  logic                busy;
  logic                req_err;
  logic [DEPTH_LOG2:0] fifo_level;
  logic [15:0]         pkt_count;

  udp_tx_packer_if bus ();

  udp_tx_packer #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .PAYLOAD_WORDS (PW),
    .GAP_CYCLES    (GAP)
  ) dut (
    .e_rxc      (e_rxc),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .fifo_level (fifo_level),
    .pkt_count  (pkt_count),
    .req_err    (req_err)
  );

  always #4 e_rxc = ~e_rxc;

  int unsigned cyc = 0;
  always @(posedge e_rxc) cyc <= cyc + 1;

  int starts = 0;
  always @(negedge e_rxc) if (bus.tx_start === 1'b1) starts++;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words, packet progress and pacing expressed at the transaction level.
  logic [31:0] mq [$];
  bit          in_start;
  bit          serving;
  int          word_idx;
  logic [15:0] seq;
  logic [31:0] exp_tx;
  bit          exp_err;
  int          pkts;
  int unsigned gap_end;
  int unsigned last_req_cyc;
  int          pushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    in_start = 0;
    serving  = 0;
    word_idx = 0;
    seq      = '0;
    exp_tx   = '0;
    exp_err  = 0;
    pkts     = 0;
    gap_end  = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    bit          acc;
    bit          begin_pkt;
    logic [31:0] w;
    check("s_ready", 32'(bus.s_ready), 32'(mq.size() < DEPTH));
    acc       = v && (mq.size() < DEPTH);
    begin_pkt = !in_start && !serving && (mq.size() >= PW) && (cyc >= gap_end);
    bus.s_valid     = v;
    bus.s_data      = d;
    bus.tx_data_req = r;
    @(posedge e_rxc);
    #1;
    if (r) begin
      if (serving) begin
        if (HDR_W == 1 && word_idx == 0) w = {16'hA55A, seq};
        else                             w = mq.pop_front();
        exp_tx = w;
        word_idx++;
        if (word_idx == TOTAL) begin
          serving      = 0;
          word_idx     = 0;
          seq          = seq + 16'd1;
          last_req_cyc = cyc - 1;
          gap_end      = cyc - 1 + GAP;
        end
      end else begin
        exp_err = 1;
      end
    end
    if (acc) begin
      mq.push_back(d);
      pushes++;
    end
    if (in_start) begin
      in_start = 0;
      serving  = 1;
      pkts++;
    end else if (begin_pkt) begin
      in_start = 1;
    end
    check("tx_start",   32'(bus.tx_start), 32'(in_start));
    check("busy",       32'(busy),         32'(in_start || serving || (cyc < gap_end)));
    check("fifo_level", 32'(fifo_level),   32'(mq.size()));
    check("tx_data",    bus.tx_data,       exp_tx);
    check("req_err",    32'(req_err),      32'(exp_err));
    bus.s_valid     = 1'b0;
    bus.tx_data_req = 1'b0;
  endtask

  // Waits (bounded) for tx_start, reports the cycle it appeared, then steps past the START cycle.
  task automatic wait_start(input string tag, output int unsigned at);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 64) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    at = cyc;
    check(tag, 32'(bus.tx_start), 32'h1);
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic serve(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    int unsigned t_start;
    int          p0;
    int          n;
    int          starts_before;
    logic [31:0] held;

    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.tx_data_req = 1'b0;
    model_reset();
    pushes = 0;
    repeat (3) @(posedge e_rxc);
    #1;

    check("rst_s_ready",   32'(bus.s_ready),    32'h1);
    check("rst_tx_start",  32'(bus.tx_start),   32'h0);
    check("rst_tx_data",   bus.tx_data,         32'h0);
    check("rst_busy",      32'(busy),           32'h0);
    check("rst_level",     32'(fifo_level),     32'h0);
    check("rst_pkt_count", 32'(pkt_count),      32'h0);
    check("rst_req_err",   32'(req_err),        32'h0);
    check("udp_length",    32'(bus.tx_data_length),  32'(8 + P_BYTES));
    check("ip_length",     32'(bus.tx_total_length), 32'(28 + P_BYTES));
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0);

    // Packet 1: sequential sample values, back-to-back requests.
    for (int i = 0; i < PW; i++) step(1'b1, 32'(i), 1'b0);
    wait_start("start_pkt1", t_start);
    serve(TOTAL);
    check("pkt1_level_empty", 32'(fifo_level), 32'h0);
    check("pkt1_pkt_count",   32'(pkt_count),  32'(pkts));
    check("pkt1_one_start",   32'(starts),     32'h1);

    // Extra request during GAP: flagged, no pop, tx_data held.
    step(1'b0, 32'h0, 1'b1);
    check("gap_req_err",   32'(req_err),    32'h1);
    check("gap_level",     32'(fifo_level), 32'h0);
    check("gap_tx_data",   bus.tx_data,     exp_tx);
    wait_idle("idle_after_pkt1");
    check("no_spurious_start", 32'(starts), 32'h1);

    // Fill the FIFO completely with random samples; packet 2 starts but is not served yet.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
    check("full_level", 32'(fifo_level),  32'(DEPTH));
    check("full_ready", 32'(bus.s_ready), 32'h0);
    held = $urandom;
    p0   = pushes;
    repeat (3) step(1'b1, held, 1'b0);
    check("full_rejects", 32'(pushes - p0), 32'h0);
    n = 0;
    while (pushes == p0 && n < 8) begin
      step(1'b1, held, 1'b1);
      n++;
    end
    check("held_word_accepted", 32'(pushes - p0), 32'h1);
    n = 0;
    while (serving && n < 2 * TOTAL) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end

    // Packet 3 is already buffered: its start is paced purely by the gap.
    wait_start("start_pkt3", t_start);
    check("gap_start_delta", t_start - last_req_cyc, 32'(GAP + 1));
    serve(TOTAL);
    check("pkt3_pkt_count", 32'(pkt_count), 32'(pkts));
    check("req_err_sticky", 32'(req_err),   32'h1);
    wait_idle("idle_after_pkt3");

    // Reset in the middle of a packet.
    for (int i = 0; i < PW; i++) step(1'b1, $urandom, 1'b0);
    wait_start("start_pkt4", t_start);
    serve(5);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge e_rxc);
    #1;
    check("midrst_level",     32'(fifo_level),  32'h0);
    check("midrst_busy",      32'(busy),        32'h0);
    check("midrst_tx_start",  32'(bus.tx_start), 32'h0);
    check("midrst_s_ready",   32'(bus.s_ready), 32'h1);
    check("midrst_pkt_count", 32'(pkt_count),   32'h0);
    check("midrst_req_err",   32'(req_err),     32'h0);
    check("midrst_tx_data",   bus.tx_data,      32'h0);
    rst = 1'b0;
    starts_before = starts;
    repeat (6) step(1'b0, 32'h0, 1'b0);
    check("midrst_no_start", 32'(starts - starts_before), 32'h0);

    // First packet after reset restarts the sequence numbering.
    for (int i = 0; i < PW; i++) step(1'b1, $urandom, 1'b0);
    wait_start("start_after_rst", t_start);
    serve(TOTAL);
    check("post_rst_pkt_count", 32'(pkt_count),  32'h1);
    check("post_rst_level",     32'(fifo_level), 32'h0);
    wait_idle("idle_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
